// File: rtl/sdm_pkg.sv
// Shared constants for the sigma-delta transmitter: default widths,
// full-scale feedback value, integrator saturation limits, loop order codes.
package sdm_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int INT_W_DEF  = 24;

  typedef enum logic {
    ORDER_FIRST  = 1'b0,
    ORDER_SECOND = 1'b1
  } order_e;

  // Feedback magnitude: one LSB above the largest positive input sample.
  function automatic longint full_scale(input int data_w);
    return longint'(1) <<< (data_w - 1);
  endfunction

  // Symmetric integrator clamp magnitude.
  function automatic longint sat_limit(input int int_w);
    return (longint'(1) <<< (int_w - 1)) - 1;
  endfunction

  localparam longint FULL_SCALE = full_scale(DATA_W_DEF);
  localparam longint SAT_LIMIT  = sat_limit(INT_W_DEF);

endpackage

// File: rtl/sdm_clkgen.sv
// Modulator clock divider: half-period counter 0..div, sd_clk toggles at the
// terminal count, and a one-cycle strobe marks the 1->0 toggle cycle.
module sdm_clkgen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] clk_div,
  output logic       sd_clk,
  output logic       bit_stb
);

  logic [7:0] cnt_reg;
  logic [7:0] div_reg;
  logic       sd_clk_reg;
  logic       tc;

  // The divisor is only re-sampled at a wrap so the counter can never run past it.
  assign tc      = (cnt_reg == div_reg);
  assign sd_clk  = sd_clk_reg;
  assign bit_stb = enable && tc && sd_clk_reg;

  // Half-period counter and sd_clk level register.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt_reg    <= 8'd0;
      div_reg    <= clk_div;
      sd_clk_reg <= 1'b0;
    end else if (tc) begin
      cnt_reg    <= 8'd0;
      div_reg    <= clk_div;
      sd_clk_reg <= ~sd_clk_reg;
    end else begin
      cnt_reg    <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/sdm_tx.sv
// First/second order 1-bit sigma-delta modulator with a one-deep sample
// holding register, saturating integrators and sticky status flags.
module sdm_tx
  import sdm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int INT_W  = INT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        clk_div,
  input  logic [7:0]        osr,
  input  logic              order,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sd_clk,
  output logic              sd_data,
  output logic              overload,
  output logic              underrun
);

  localparam int SUM_W = INT_W + 2;
  localparam logic signed [SUM_W-1:0] FS_S   = SUM_W'(full_scale(DATA_W));
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_limit(INT_W));
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

  logic signed [INT_W-1:0]  int1_reg, int2_reg;
  logic signed [INT_W-1:0]  int1_next, int2_next;
  logic signed [DATA_W-1:0] active_reg, hold_reg;
  logic                     hold_full_reg;
  logic [7:0]               bcnt_reg, osr_reg;
  logic                     sd_data_reg, overload_reg, underrun_reg;

  logic                     bit_stb, wrap, hs, bit_now, second, sat_any;
  logic signed [SUM_W-1:0]  x_ext, fb, i1_ext, i2_ext, i1n_ext, sum1, sum2;

  sdm_clkgen u_clkgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clk_div (clk_div),
    .sd_clk  (sd_clk),
    .bit_stb (bit_stb)
  );

  // A wrap empties the holding register in the same cycle, so it can take a new sample then.
  assign wrap         = bit_stb && (bcnt_reg == osr_reg);
  assign sample_ready = rst_n && enable && (!hold_full_reg || wrap);
  assign hs           = sample_valid && sample_ready;
  assign sd_data      = sd_data_reg;
  assign overload     = overload_reg;
  assign underrun     = underrun_reg;

  // Loop arithmetic: decide the bit from the old integrator, then saturating updates.
  always_comb begin
    second  = (order_e'(order) == ORDER_SECOND);
    bit_now = second ? !int2_reg[INT_W-1] : !int1_reg[INT_W-1];
    fb      = bit_now ? FS_S : -FS_S;
    x_ext   = {{(SUM_W-DATA_W){active_reg[DATA_W-1]}}, active_reg};
    i1_ext  = {{2{int1_reg[INT_W-1]}}, int1_reg};
    i2_ext  = {{2{int2_reg[INT_W-1]}}, int2_reg};
    sum1    = i1_ext + x_ext - fb;
    int1_next = sum1[INT_W-1:0];
    sat_any = 1'b0;
    if (sum1 > SAT_HI) begin
      int1_next = SAT_HI[INT_W-1:0];
      sat_any   = 1'b1;
    end else if (sum1 < SAT_LO) begin
      int1_next = SAT_LO[INT_W-1:0];
      sat_any   = 1'b1;
    end
    i1n_ext   = {{2{int1_next[INT_W-1]}}, int1_next};
    sum2      = i2_ext + i1n_ext - fb;
    int2_next = sum2[INT_W-1:0];
    if (sum2 > SAT_HI) begin
      int2_next = SAT_HI[INT_W-1:0];
      sat_any   = sat_any || second;
    end else if (sum2 < SAT_LO) begin
      int2_next = SAT_LO[INT_W-1:0];
      sat_any   = sat_any || second;
    end
  end

  // Modulator state: integrators, bit counter, sample registers and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      int1_reg      <= '0;
      int2_reg      <= '0;
      active_reg    <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      bcnt_reg      <= 8'd0;
      osr_reg       <= osr;
      sd_data_reg   <= 1'b0;
      overload_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      if (bit_stb) begin
        int1_reg    <= int1_next;
        if (second) begin
          int2_reg  <= int2_next;
        end
        sd_data_reg <= bit_now;
        if (sat_any) begin
          overload_reg <= 1'b1;
        end
        if (wrap) begin
          bcnt_reg <= 8'd0;
          osr_reg  <= osr;
          if (hold_full_reg) begin
            active_reg <= hold_reg;
          end else begin
            underrun_reg <= 1'b1;
          end
        end else begin
          bcnt_reg <= bcnt_reg + 8'd1;
        end
      end
      if (hs) begin
        hold_reg      <= sample;
        hold_full_reg <= 1'b1;
      end else if (wrap) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

endmodule
